// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, flag bit positions and the issue-controller state encoding.
package alu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_NOT  = 8'h07;
    localparam logic [7:0] OP_NAND = 8'h08;
    localparam logic [7:0] OP_NOR  = 8'h09;
    localparam logic [7:0] OP_XNOR = 8'h0A;
    localparam logic [7:0] OP_SHL  = 8'h0B;
    localparam logic [7:0] OP_SHR  = 8'h0C;
    localparam logic [7:0] OP_CMP  = 8'h0D;

    localparam logic [7:0] OP_MIN  = OP_ADD;
    localparam logic [7:0] OP_MAX  = OP_CMP;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_S = 2;
    localparam int FLG_P = 3;
    localparam int FLG_V = 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op >= OP_MIN) && (op <= OP_MAX);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time, waits out the ALU pipeline, and returns result/flags;
// also keeps the architectural flag register (psw) and a completed-operation counter.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_x,
    output logic [7:0]       rsp_flags,
    output logic             rsp_err,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [7:0]       alu_sel,
    input  logic [7:0]       alu_x,
    input  logic [7:0]       alu_flags,
    output logic [7:0]       psw,
    output logic [CNT_W-1:0] op_count
);

    localparam int WCNT_W = $clog2(ALU_LATENCY + 1);

    logic [1:0]        state;
    logic [WCNT_W-1:0] wait_cnt;

    assign rsp_valid = (state == ST_RESP);

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            wait_cnt  <= '0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_sel   <= OP_NOP;
            rsp_x     <= 8'h00;
            rsp_flags <= 8'h00;
            rsp_err   <= 1'b0;
            psw       <= 8'h00;
            op_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (is_legal_op(req_op)) begin
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                            alu_sel  <= req_op;
                            wait_cnt <= WCNT_W'(ALU_LATENCY);
                            state    <= ST_WAIT;
                        end else begin
                            // Illegal opcodes never reach the ALU; answer immediately with an error.
                            rsp_x     <= 8'h00;
                            rsp_flags <= 8'h00;
                            rsp_err   <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WCNT_W'(1)) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    rsp_x     <= alu_x;
                    rsp_flags <= alu_flags;
                    rsp_err   <= 1'b0;
                    psw       <= alu_flags;
                    alu_sel   <= OP_NOP;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (!rsp_err) begin
                            op_count <= op_count + 1'b1;
                        end
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a two-stage registered ALU stub.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_op, req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_x, rsp_flags;
    logic        rsp_err;
    logic [7:0]  alu_a, alu_b, alu_sel;
    logic [7:0]  alu_x, alu_flags;
    logic [7:0]  psw;
    logic [15:0] op_count;

    // Narrow-counter twin sharing all inputs, used to exercise counter wrap in few ops.
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [7:0]  w_rsp_x, w_rsp_flags, w_alu_a, w_alu_b, w_alu_sel, w_psw;
    logic [2:0]  w_op_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int model_cnt = 0;
    logic [7:0] model_psw = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.ALU_LATENCY(LAT), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_x(alu_x), .alu_flags(alu_flags),
        .psw(psw), .op_count(op_count)
    );

    alu_issue_ctrl #(.ALU_LATENCY(LAT), .CNT_W(3)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(w_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(w_rsp_x), .rsp_flags(w_rsp_flags), .rsp_err(w_rsp_err),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sel(w_alu_sel),
        .alu_x(alu_x), .alu_flags(alu_flags),
        .psw(w_psw), .op_count(w_op_count)
    );

    // ALU stub: a no-op selector yields a poison value so early or late capture is visible.
    function automatic logic [15:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, f;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_NOP: return 16'hEEEE;
            OP_ADD: begin {c, x} = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (x[7] != a[7]); end
            OP_SUB: begin {c, x} = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (x[7] != a[7]); end
            OP_AND: x = a & b;
            OP_OR:  x = a | b;
            OP_XOR: x = a ^ b;
            default: x = a;
        endcase
        f = 8'h00;
        f[FLG_Z] = (x == 8'h00);
        f[FLG_C] = c;
        f[FLG_S] = x[7];
        f[FLG_P] = ~^x;
        f[FLG_V] = v;
        return {x, f};
    endfunction

    logic [7:0] s1_x, s1_f;
    always @(posedge clk) begin
        {s1_x, s1_f}      <= alu_model(alu_sel, alu_a, alu_b);
        {alu_x, alu_flags} <= {s1_x, s1_f};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a request once req_ready is seen; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 30) begin @(negedge clk); n++; end
        check("issue_ready", 32'(req_ready), 32'd1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits for rsp_valid, checking latency, how long alu_sel carried the op, and the payload.
    task automatic await_rsp(input string name, input logic [7:0] op,
                             input logic [7:0] ex, input logic [7:0] ef, input logic ee);
        int n = 0;
        int sel_cycles = 0;
        while (!rsp_valid && n < 30) begin
            if (alu_sel == op) sel_cycles++;
            @(negedge clk);
            n++;
        end
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_latency"}, 32'(cyc - acc), ee ? 32'd0 : 32'(LAT + 1));
        check({name, "_sel_cycles"}, 32'(sel_cycles), ee ? 32'd0 : 32'(LAT + 1));
        check({name, "_sel_after"}, 32'(alu_sel), 32'h00);
        check({name, "_x"}, 32'(rsp_x), 32'(ex));
        check({name, "_flags"}, 32'(rsp_flags), 32'(ef));
        check({name, "_err"}, 32'(rsp_err), 32'(ee));
        if (!ee) begin
            model_cnt++;
            model_psw = ef;
        end
    endtask

    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({name, "_ready_back"}, 32'(req_ready), 32'd1);
        check({name, "_op_count"}, 32'(op_count), 32'(model_cnt));
        check({name, "_psw"}, 32'(psw), 32'(model_psw));
    endtask

    typedef struct {
        logic [7:0] op, a, b, x, f;
        logic       err;
    } vec_t;

    vec_t vecs [11];
    int   acc_t [3];

    initial begin
        vecs[0]  = '{op: 8'h01, a: 8'h7F, b: 8'h01, x: 8'h80, f: 8'h44, err: 1'b0};
        vecs[1]  = '{op: 8'h01, a: 8'hFF, b: 8'h01, x: 8'h00, f: 8'h0B, err: 1'b0};
        vecs[2]  = '{op: 8'h02, a: 8'h05, b: 8'h03, x: 8'h02, f: 8'h00, err: 1'b0};
        vecs[3]  = '{op: 8'h02, a: 8'h03, b: 8'h05, x: 8'hFE, f: 8'h06, err: 1'b0};
        vecs[4]  = '{op: 8'h00, a: 8'h12, b: 8'h34, x: 8'h00, f: 8'h00, err: 1'b1};
        vecs[5]  = '{op: 8'h04, a: 8'hF0, b: 8'h3C, x: 8'h30, f: 8'h08, err: 1'b0};
        vecs[6]  = '{op: 8'h05, a: 8'h0F, b: 8'hF0, x: 8'hFF, f: 8'h0C, err: 1'b0};
        vecs[7]  = '{op: 8'h0E, a: 8'h12, b: 8'h34, x: 8'h00, f: 8'h00, err: 1'b1};
        vecs[8]  = '{op: 8'h06, a: 8'hAA, b: 8'hAA, x: 8'h00, f: 8'h09, err: 1'b0};
        vecs[9]  = '{op: 8'h0D, a: 8'h81, b: 8'h00, x: 8'h81, f: 8'h0C, err: 1'b0};
        vecs[10] = '{op: 8'hFF, a: 8'h55, b: 8'h66, x: 8'h00, f: 8'h00, err: 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 8'h00; req_a = 8'h00; req_b = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'h00);
        check("rst_psw", 32'(psw), 32'h00);
        check("rst_op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Basic legal op, then an illegal one that must leave psw/op_count alone.
        issue(8'h01, 8'h7F, 8'h01);
        check("add_alu_a", 32'(alu_a), 32'h7F);
        check("add_alu_b", 32'(alu_b), 32'h01);
        await_rsp("add", 8'h01, 8'h80, 8'h44, 1'b0);
        handshake("add");
        issue(8'h0E, 8'h12, 8'h34);
        await_rsp("ill", 8'h0E, 8'h00, 8'h00, 1'b1);
        handshake("ill");

        // Back-pressure: response held 5 cycles while a new request waits.
        issue(8'h01, 8'hFF, 8'h01);
        await_rsp("bp", 8'h01, 8'h00, 8'h0B, 1'b0);
        req_op = 8'h02; req_a = 8'h03; req_b = 8'h05; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_x", 32'(rsp_x), 32'h00);
            check("bp_hold_flags", 32'(rsp_flags), 32'h0B);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_sel", 32'(alu_sel), 32'h00);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_hs_sel", 32'(alu_sel), 32'h00);
        check("bp_hs_ready", 32'(req_ready), 32'd1);
        check("bp_hs_count", 32'(op_count), 32'(model_cnt));
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_sel", 32'(alu_sel), 32'h02);
        await_rsp("bp_next", 8'h02, 8'hFE, 8'h06, 1'b0);
        handshake("bp_next");

        // Reset pulse during WAIT discards the op.
        issue(8'h02, 8'h05, 8'h03);
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        model_psw = 8'h00;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_alu_sel", 32'(alu_sel), 32'h00);
        check("arst_alu_ab", 32'({alu_a, alu_b}), 32'h0000);
        check("arst_rsp", 32'({rsp_valid, rsp_err, rsp_x, rsp_flags}), 32'h0);
        check("arst_psw", 32'(psw), 32'h00);
        check("arst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("arst_no_rsp", 32'(seen), 32'd0);
        end
        issue(8'h01, 8'h7F, 8'h01);
        await_rsp("arst_add", 8'h01, 8'h80, 8'h44, 1'b0);
        handshake("arst_add");

        // Back-to-back with rsp_ready tied high: acceptances exactly LAT+3 apart.
        begin
            logic [7:0] bop [3];
            logic [7:0] ba  [3];
            logic [7:0] bb  [3];
            int k = 0;
            int n = 0;
            bop[0] = 8'h01; ba[0] = 8'h7F; bb[0] = 8'h01;
            bop[1] = 8'h04; ba[1] = 8'hF0; bb[1] = 8'h3C;
            bop[2] = 8'h02; ba[2] = 8'h03; bb[2] = 8'h05;
            rsp_ready = 1'b1;
            @(negedge clk);
            req_op = bop[0]; req_a = ba[0]; req_b = bb[0]; req_valid = 1'b1;
            while (k < 3 && n < 40) begin
                if (req_valid && req_ready) begin
                    acc_t[k] = cyc + 1;
                    k++;
                    @(negedge clk);
                    if (k < 3) begin
                        req_op = bop[k]; req_a = ba[k]; req_b = bb[k];
                    end else begin
                        req_valid = 1'b0;
                    end
                end else begin
                    @(negedge clk);
                end
                n++;
            end
            check("b2b_accepts", 32'(k), 32'd3);
            repeat (8) @(negedge clk);
            rsp_ready = 1'b0;
            model_cnt += 3;
            model_psw = 8'h06;
            check("b2b_gap01", 32'(acc_t[1] - acc_t[0]), 32'(LAT + 3));
            check("b2b_gap12", 32'(acc_t[2] - acc_t[1]), 32'(LAT + 3));
            check("b2b_op_count", 32'(op_count), 32'(model_cnt));
            check("b2b_psw", 32'(psw), 32'h06);
        end

        // Table-driven vectors.
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            await_rsp(nm, vecs[i].op, vecs[i].x, vecs[i].f, vecs[i].err);
            handshake(nm);
        end

        check("final_op_count", 32'(op_count), 32'(model_cnt));
        check("wrap_op_count", 32'(w_op_count), 32'(model_cnt % 8));
        check("wrap_passed", 32'(model_cnt >= 8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
